// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: arbitrates the two dcache coherence ports, issues MSI
// snoops, forwards M-line data cache-to-cache and drives the single RAM port.
module coherence_bus_ctrl #(
  parameter int WORDS_PER_BLK = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][ADDR_W-1:0] daddr,
  input  logic [1:0][DATA_W-1:0] dstore,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             dwait,
  output logic [1:0][DATA_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  input  logic [DATA_W-1:0]      ramload,
  input  logic                   ram_wait
);

  localparam int CW = $clog2(WORDS_PER_BLK) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_BLK);

  typedef enum logic [2:0] {IDLE, EVICT, UPG, SNOOP, C2C, LD} state_e;

  state_e        state_q, state_d;
  logic          r_q, r_d;
  logic          rr_q, rr_d;
  logic          snp_q, snp_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic [1:0]    req;
  logic          o, live, ack, gnt;
  logic [CW-1:0] wnext;

  assign req   = cctrans | dREN | dWEN;
  assign o     = ~r_q;
  assign live  = req[r_q];
  assign wnext = wcnt_q + 1'b1;

  // Acks follow ram_wait in the same cycle, so outputs decode state + inputs.
  always_comb begin
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    ack         = 1'b0;
    unique case (state_q)
      UPG: begin
        ccwait[o]      = 1'b1;
        ccinv[o]       = 1'b1;
        ccsnoopaddr[o] = daddr[r_q];
        dwait[r_q]     = 1'b0;
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccinv[o]       = ccwrite[r_q];
        ccsnoopaddr[o] = daddr[r_q];
      end
      EVICT: begin
        if (live) begin
          ramWEN     = 1'b1;
          ramaddr    = daddr[r_q];
          ramstore   = dstore[r_q];
          ack        = ~ram_wait;
          dwait[r_q] = ram_wait;
        end
      end
      C2C: begin
        ccwait[o] = 1'b1;
        if (live) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[o];
          ramstore = dstore[o];
          ack      = ~ram_wait & dWEN[o];
          if (ack) begin
            dwait[o]   = 1'b0;
            dwait[r_q] = 1'b0;
            dload[r_q] = dstore[o];
          end
        end
      end
      LD: begin
        ccwait[o] = snp_q;
        if (live) begin
          ramREN  = 1'b1;
          ramaddr = daddr[r_q];
          ack     = ~ram_wait;
          if (ack) begin
            dwait[r_q] = 1'b0;
            dload[r_q] = ramload;
          end
        end
      end
      default: ;
    endcase
  end

  // rr_q names the cache that wins the next tie.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    rr_d    = rr_q;
    snp_d   = snp_q;
    wcnt_d  = wcnt_q;
    gnt     = rr_q;
    if (req == 2'b01)
      gnt = 1'b0;
    else if (req == 2'b10)
      gnt = 1'b1;
    unique case (state_q)
      IDLE: begin
        snp_d  = 1'b0;
        wcnt_d = '0;
        if (|req) begin
          r_d  = gnt;
          rr_d = ~gnt;
          if (dWEN[gnt] & ~cctrans[gnt])
            state_d = EVICT;
          else if (cctrans[gnt] & ccwrite[gnt] & ~dREN[gnt])
            state_d = UPG;
          else if (cctrans[gnt]) begin
            state_d = SNOOP;
            snp_d   = 1'b1;
          end else
            state_d = LD;
        end
      end
      UPG:   state_d = IDLE;
      SNOOP: state_d = ccwrite[o] ? C2C : LD;
      default: begin
        if (!live) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (ack) begin
          if (wnext == LAST) begin
            state_d = IDLE;
            wcnt_d  = '0;
          end else
            wcnt_d = wnext;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= 1'b0;
      rr_q    <= 1'b0;
      snp_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rr_q    <= rr_d;
      snp_q   <= snp_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed vector table, hand sequences for
// arbitration/abort/reset, and randomized transactions vs a reference model.
module tb_coherence_bus_ctrl;

  localparam int WPB = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite;
  logic [1:0]       dwait, ccwait, ccinv;
  logic [1:0][31:0] daddr, dstore, dload, ccsnoopaddr;
  logic             ramREN, ramWEN, ram_wait;
  logic [31:0]      ramaddr, ramstore, ramload;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.WORDS_PER_BLK(WPB), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_wait(ram_wait)
  );

  // expected outputs for the current cycle
  logic [1:0]       x_dwait, x_ccwait, x_ccinv, x_sav;
  logic             x_ren, x_wen;
  logic [31:0]      x_addr, x_store;
  logic [1:0][31:0] x_dl, x_sa;

  typedef struct {
    string       nm;
    logic [1:0]  ren, wen, ctr, cw;
    logic [31:0] a0, a1, s0, s1, rl;
    logic        rw;
    logic [1:0]  dw, ccw, cci;
    logic        rren, rwen;
    logic [31:0] ra, rs, dl0, dl1;
    logic [1:0]  sav;
    logic [31:0] sa;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string nm,
    input logic [1:0] ren, input logic [1:0] wen,
    input logic [1:0] ctr, input logic [1:0] cw,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] s0, input logic [31:0] s1,
    input logic [31:0] rl, input logic rw,
    input logic [1:0] dw, input logic [1:0] ccw, input logic [1:0] cci,
    input logic rren, input logic rwen,
    input logic [31:0] ra, input logic [31:0] rs,
    input logic [31:0] dl0, input logic [31:0] dl1,
    input logic [1:0] sav, input logic [31:0] sa);
    vec_t v;
    v.nm = nm; v.ren = ren; v.wen = wen; v.ctr = ctr; v.cw = cw;
    v.a0 = a0; v.a1 = a1; v.s0 = s0; v.s1 = s1; v.rl = rl; v.rw = rw;
    v.dw = dw; v.ccw = ccw; v.cci = cci; v.rren = rren; v.rwen = rwen;
    v.ra = ra; v.rs = rs; v.dl0 = dl0; v.dl1 = dl1; v.sav = sav; v.sa = sa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic xidle();
    x_dwait = 2'b11; x_ccwait = '0; x_ccinv = '0; x_sav = '0;
    x_ren = 1'b0; x_wen = 1'b0; x_addr = '0; x_store = '0;
    x_dl = '0; x_sa = '0;
  endtask

  task automatic clr();
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    daddr = '0; dstore = '0; ramload = '0; ram_wait = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp_now(input string t);
    chk({t, ".dwait"},  64'(dwait),    64'(x_dwait));
    chk({t, ".ccwait"}, 64'(ccwait),   64'(x_ccwait));
    chk({t, ".ccinv"},  64'(ccinv),    64'(x_ccinv));
    chk({t, ".ramREN"}, 64'(ramREN),   64'(x_ren));
    chk({t, ".ramWEN"}, 64'(ramWEN),   64'(x_wen));
    chk({t, ".raddr"},  64'(ramaddr),  64'(x_addr));
    chk({t, ".rstore"}, 64'(ramstore), 64'(x_store));
    chk({t, ".dload0"}, 64'(dload[0]), 64'(x_dl[0]));
    chk({t, ".dload1"}, 64'(dload[1]), 64'(x_dl[1]));
    for (int i = 0; i < 2; i++)
      if (x_sav[i])
        chk({t, ".snpaddr"}, 64'(ccsnoopaddr[i]), 64'(x_sa[i]));
  endtask

  task automatic cmp_all(input string t);
    @(negedge CLK);
    cmp_now(t);
    step();
  endtask

  // random transaction state: 0 evict, 1 upgrade, 2 read miss,
  // 3 write miss, 4 plain load
  int          kd[2];
  logic [31:0] ba[2];
  int          nxt;

  task automatic drive_req(input int c);
    dREN[c]    = (kd[c] == 2 || kd[c] == 3 || kd[c] == 4);
    dWEN[c]    = (kd[c] == 0);
    cctrans[c] = (kd[c] == 1 || kd[c] == 2 || kd[c] == 3);
    ccwrite[c] = (kd[c] == 1 || kd[c] == 3);
    daddr[c]   = ba[c];
    dstore[c]  = $urandom;
  endtask

  task automatic drive_idle(input int c, input logic m);
    dREN[c] = 1'b0; dWEN[c] = 1'b0; cctrans[c] = 1'b0;
    ccwrite[c] = m; daddr[c] = '0; dstore[c] = '0;
  endtask

  // mode 0 evict, 1 RAM load, 2 cache-to-cache
  task automatic words(input int r, input int mode, input logic coh);
    int o = 1 - r;
    for (int w = 0; w < WPB; w++) begin
      logic [31:0] a;
      logic rdy;
      int tries;
      a = ba[r] + 32'(4 * w);
      rdy = 1'b0;
      tries = 0;
      while (!rdy) begin
        logic rw, dwe;
        logic [31:0] d;
        rw  = (tries < 3) ? 1'($urandom_range(1)) : 1'b0;
        dwe = (mode != 2) ? 1'b0 :
              (tries < 3) ? 1'($urandom_range(1)) : 1'b1;
        rdy = !rw && (mode != 2 || dwe);
        d = $urandom;
        ram_wait = rw;
        daddr[r] = a;
        xidle();
        if (mode == 0) begin
          dstore[r] = d;
          x_wen = 1'b1; x_addr = a; x_store = d;
          if (rdy) x_dwait[r] = 1'b0;
        end else if (mode == 1) begin
          ramload = d;
          x_ren = 1'b1; x_addr = a; x_ccwait[o] = coh;
          if (rdy) begin x_dwait[r] = 1'b0; x_dl[r] = d; end
        end else begin
          dWEN[o] = dwe; daddr[o] = a; dstore[o] = d;
          x_wen = 1'b1; x_addr = a; x_store = d; x_ccwait[o] = 1'b1;
          if (rdy) begin x_dwait = 2'b00; x_dl[r] = d; end
        end
        cmp_all("rnd_word");
        tries++;
      end
      if (mode == 2) dWEN[o] = 1'b0;
    end
  endtask

  task automatic serve(input int r, input logic opend);
    int o = 1 - r;
    logic mo;
    mo = !opend && (kd[r] == 2 || kd[r] == 3) && 1'($urandom_range(1));
    drive_req(r);
    if (opend) drive_req(o);
    else drive_idle(o, mo);
    ram_wait = 1'($urandom_range(1));
    ramload = $urandom;
    xidle();
    cmp_all("rnd_grant");
    if (kd[r] == 1) begin
      xidle();
      x_ccwait[o] = 1'b1; x_ccinv[o] = 1'b1; x_dwait[r] = 1'b0;
      x_sav[o] = 1'b1; x_sa[o] = ba[r];
      cmp_all("rnd_upg");
    end else if (kd[r] == 2 || kd[r] == 3) begin
      xidle();
      x_ccwait[o] = 1'b1; x_ccinv[o] = (kd[r] == 3);
      x_sav[o] = 1'b1; x_sa[o] = ba[r];
      cmp_all("rnd_snoop");
      words(r, mo ? 2 : 1, 1'b1);
    end else if (kd[r] == 0) begin
      words(r, 0, 1'b0);
    end else begin
      words(r, 1, 1'b0);
    end
  endtask

  initial begin
    clr();
    xidle();
    repeat (2) @(posedge CLK);
    #1;
    cmp_now("reset");
    RST = 1'b0;

    // T3: tie after reset goes to c0, then c1, next tie to c0 again
    dREN = 2'b11; cctrans = 2'b11;
    daddr[0] = 32'h500; daddr[1] = 32'h600; ramload = 32'h5;
    cmp_all("t3_idle");
    @(negedge CLK); chk("t3_first", 64'(ccwait), 64'(2'b10)); step();
    repeat (WPB) begin
      @(negedge CLK); chk("t3_c0_word", 64'(dwait), 64'(2'b10)); step();
    end
    dREN[0] = 1'b0; cctrans[0] = 1'b0;
    @(negedge CLK); chk("t3_gap", 64'(dwait), 64'(2'b11)); step();
    @(negedge CLK); chk("t3_second", 64'(ccwait), 64'(2'b01)); step();
    repeat (WPB) begin
      @(negedge CLK); chk("t3_c1_word", 64'(dwait), 64'(2'b01)); step();
    end
    dREN = 2'b11; cctrans = 2'b11;
    @(negedge CLK); chk("t3_gap2", 64'(dwait), 64'(2'b11)); step();
    @(negedge CLK); chk("t3_third", 64'(ccwait), 64'(2'b10)); step();
    repeat (WPB) begin
      @(negedge CLK); chk("t3_c0_again", 64'(dwait), 64'(2'b10)); step();
    end
    clr();
    xidle();
    cmp_all("t3_end");

    // vector table: T1 read miss, T2 write miss C2C, T4 upgrade, T5 evict
    tbl.push_back(mk("t1_idle",  2'b01,0,2'b01,0, 32'h100,0,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk("t1_snoop", 2'b01,0,2'b01,0, 32'h100,0,0,0,0,0, 2'b11,2'b10,0, 0,0, 0,0,0,0, 2'b10,32'h100));
    tbl.push_back(mk("t1_w0",    2'b01,0,2'b01,0, 32'h100,0,0,0,32'hA,0, 2'b10,2'b10,0, 1,0, 32'h100,0,32'hA,0, 0,0));
    tbl.push_back(mk("t1_w1",    2'b01,0,2'b01,0, 32'h104,0,0,0,32'hB,0, 2'b10,2'b10,0, 1,0, 32'h104,0,32'hB,0, 0,0));
    tbl.push_back(mk("t1_done",  0,0,0,0, 0,0,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk("t2_idle",  2'b10,0,2'b10,2'b11, 32'h200,32'h200,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk("t2_snoop", 2'b10,0,2'b10,2'b11, 32'h200,32'h200,0,0,0,0, 2'b11,2'b01,2'b01, 0,0, 0,0,0,0, 2'b01,32'h200));
    tbl.push_back(mk("t2_w0",    2'b10,2'b01,2'b10,2'b11, 32'h200,32'h200,32'h11,0,0,0, 2'b00,2'b01,0, 0,1, 32'h200,32'h11,0,32'h11, 0,0));
    tbl.push_back(mk("t2_w1",    2'b10,2'b01,2'b10,2'b11, 32'h204,32'h200,32'h22,0,0,0, 2'b00,2'b01,0, 0,1, 32'h204,32'h22,0,32'h22, 0,0));
    tbl.push_back(mk("t2_done",  0,0,0,0, 0,0,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk("t4_idle",  0,0,2'b01,2'b01, 32'h300,0,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk("t4_upg",   0,0,2'b01,2'b01, 32'h300,0,0,0,0,0, 2'b10,2'b10,2'b10, 0,0, 0,0,0,0, 2'b10,32'h300));
    tbl.push_back(mk("t4_done",  0,0,0,0, 0,0,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    tbl.push_back(mk("t5_idle",  0,2'b10,0,0, 0,32'h400,0,32'h55,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));
    repeat (3)
      tbl.push_back(mk("t5_w0_wait", 0,2'b10,0,0, 0,32'h400,0,32'h55,0,1, 2'b11,0,0, 0,1, 32'h400,32'h55,0,0, 0,0));
    tbl.push_back(mk("t5_w0",    0,2'b10,0,0, 0,32'h400,0,32'h55,0,0, 2'b01,0,0, 0,1, 32'h400,32'h55,0,0, 0,0));
    repeat (3)
      tbl.push_back(mk("t5_w1_wait", 0,2'b10,0,0, 0,32'h404,0,32'h66,0,1, 2'b11,0,0, 0,1, 32'h404,32'h66,0,0, 0,0));
    tbl.push_back(mk("t5_w1",    0,2'b10,0,0, 0,32'h404,0,32'h66,0,0, 2'b01,0,0, 0,1, 32'h404,32'h66,0,0, 0,0));
    tbl.push_back(mk("t5_done",  0,0,0,0, 0,0,0,0,0,0, 2'b11,0,0, 0,0, 0,0,0,0, 0,0));

    foreach (tbl[i]) begin
      dREN = tbl[i].ren; dWEN = tbl[i].wen;
      cctrans = tbl[i].ctr; ccwrite = tbl[i].cw;
      daddr[0] = tbl[i].a0; daddr[1] = tbl[i].a1;
      dstore[0] = tbl[i].s0; dstore[1] = tbl[i].s1;
      ramload = tbl[i].rl; ram_wait = tbl[i].rw;
      x_dwait = tbl[i].dw; x_ccwait = tbl[i].ccw; x_ccinv = tbl[i].cci;
      x_ren = tbl[i].rren; x_wen = tbl[i].rwen;
      x_addr = tbl[i].ra; x_store = tbl[i].rs;
      x_dl[0] = tbl[i].dl0; x_dl[1] = tbl[i].dl1;
      x_sav = tbl[i].sav; x_sa[0] = tbl[i].sa; x_sa[1] = tbl[i].sa;
      cmp_all(tbl[i].nm);
    end

    // dropped request mid-block aborts; the next block restarts at word 0
    clr();
    dREN[0] = 1'b1; daddr[0] = 32'h700; ramload = 32'h1;
    xidle(); cmp_all("ab_idle");
    xidle(); x_dwait = 2'b10; x_ren = 1'b1; x_addr = 32'h700; x_dl[0] = 32'h1;
    cmp_all("ab_w0");
    dREN[0] = 1'b0;
    @(negedge CLK); chk("ab_nopulse", 64'(dwait), 64'(2'b11)); step();
    dREN[0] = 1'b1; daddr[0] = 32'h800; ramload = 32'h2;
    xidle(); cmp_all("ab_back_idle");
    xidle(); x_dwait = 2'b10; x_ren = 1'b1; x_addr = 32'h800; x_dl[0] = 32'h2;
    cmp_all("ab_re_w0");
    daddr[0] = 32'h804; ramload = 32'h3;
    xidle(); x_dwait = 2'b10; x_ren = 1'b1; x_addr = 32'h804; x_dl[0] = 32'h3;
    cmp_all("ab_re_w1");
    clr(); xidle(); cmp_all("ab_end");

    // T6: asynchronous reset during the second LD word
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h900; ramload = 32'h77;
    xidle(); cmp_all("t6_idle");
    xidle(); x_ccwait = 2'b10; x_sav = 2'b10; x_sa[1] = 32'h900;
    cmp_all("t6_snoop");
    xidle(); x_ccwait = 2'b10; x_ren = 1'b1; x_addr = 32'h900;
    x_dwait = 2'b10; x_dl[0] = 32'h77;
    cmp_all("t6_w0");
    daddr[0] = 32'h904;
    @(negedge CLK);
    chk("t6_w1_active", 64'(ramREN), 64'(1'b1));
    #1 RST = 1'b1;
    #1 xidle();
    cmp_now("t6_async");
    step();
    RST = 1'b0;
    clr();
    xidle(); cmp_all("t6_post");

    // randomized transactions against the reference model
    nxt = 0;
    for (int it = 0; it < 150; it++) begin
      logic [1:0] pend;
      if ($urandom_range(2) == 0) begin
        pend = 2'b11;
        for (int c = 0; c < 2; c++) begin
          int k;
          k = $urandom_range(2);
          kd[c] = (k == 0) ? 0 : (k == 1) ? 2 : 4;
        end
      end else begin
        int c;
        c = $urandom_range(1);
        pend = (c == 0) ? 2'b01 : 2'b10;
        kd[c] = $urandom_range(4);
      end
      for (int c = 0; c < 2; c++)
        ba[c] = $urandom & 32'h0000_FFF8;
      while (pend != 2'b00) begin
        int w;
        w = (pend == 2'b11) ? nxt : (pend[1] ? 1 : 0);
        nxt = 1 - w;
        serve(w, pend[1-w]);
        pend[w] = 1'b0;
      end
    end
    clr();
    xidle();
    cmp_all("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
